// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receiver.
package ps2_pkg;

  localparam int unsigned START_HOLD     = 16;
  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned BIT_IDX_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    WAIT_IDLE,
    ERR
  } ps2_state_e;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines, with a clock falling-edge flag.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fe
);

  logic clk_m;
  logic data_m;

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_m  <= 1'b1;
      clk_s  <= 1'b1;
      data_m <= 1'b1;
      data_s <= 1'b1;
      clk_fe <= 1'b0;
    end else begin
      clk_m  <= ps2_clk_in;
      clk_s  <= clk_m;
      data_m <= ps2_data_in;
      data_s <= data_m;
      clk_fe <= clk_s & ~clk_m;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, device-clocked byte/parity/stop, ack check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 4800,
  parameter int unsigned TIMEOUT_CYCLES = 720000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_REQ,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE
);

  localparam int unsigned HOLD_MAX = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int unsigned WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BIT_IDX_W-1:0] PAR_IDX  = BIT_IDX_W'(PS2_FRAME_BITS - 3);
  localparam logic [BIT_IDX_W-1:0] STOP_IDX = BIT_IDX_W'(PS2_FRAME_BITS - 2);

  ps2_state_e           state, state_nx;
  logic [HOLD_W-1:0]    hold_cnt, hold_nx;
  logic [WD_W-1:0]      wd_cnt, wd_nx, wd_inc;
  logic [BIT_IDX_W-1:0] bit_idx, idx_nx;
  logic [7:0]           tx_byte, byte_nx;
  logic                 clk_oe_nx, data_oe_nx, busy_nx, done_nx, err_nx;
  logic                 clk_s, data_s, clk_fe;
  logic                 watched;

  ps2_line_sync u_sync (
    .clk        (CLOCK),
    .rst        (RESET),
    .ps2_clk_in (PS2_CLK_IN),
    .ps2_data_in(PS2_DATA_IN),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .clk_fe     (clk_fe)
  );

  // State, counters and output registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      wd_cnt      <= '0;
      bit_idx     <= '0;
      tx_byte     <= '0;
      PS2_CLK_OE  <= 1'b0;
      PS2_DATA_OE <= 1'b0;
      TX_BUSY     <= 1'b0;
      TX_DONE     <= 1'b0;
      TX_ERR      <= 1'b0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      wd_cnt      <= wd_nx;
      bit_idx     <= idx_nx;
      tx_byte     <= byte_nx;
      PS2_CLK_OE  <= clk_oe_nx;
      PS2_DATA_OE <= data_oe_nx;
      TX_BUSY     <= busy_nx;
      TX_DONE     <= done_nx;
      TX_ERR      <= err_nx;
    end
  end

  // Next state; outputs are decoded from the next state so they change with it.
  always_comb begin
    state_nx   = state;
    hold_nx    = hold_cnt;
    wd_nx      = wd_cnt;
    idx_nx     = bit_idx;
    byte_nx    = tx_byte;
    data_oe_nx = PS2_DATA_OE;
    clk_oe_nx  = 1'b0;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    wd_inc     = (&wd_cnt) ? wd_cnt : wd_cnt + WD_W'(1);
    watched    = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);

    if (watched) wd_nx = clk_fe ? '0 : wd_inc;

    case (state)
      IDLE: begin
        if (TX_REQ) begin
          state_nx = INHIBIT;
          byte_nx  = TX_DATA;
          hold_nx  = '0;
          wd_nx    = '0;
          idx_nx   = '0;
        end
      end
      INHIBIT: begin
        if (hold_cnt == HOLD_W'(INHIBIT_CYCLES - 1)) begin
          state_nx = START;
          hold_nx  = '0;
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      START: begin
        if (hold_cnt == HOLD_W'(START_HOLD - 1)) begin
          state_nx = SEND;
          hold_nx  = '0;
          idx_nx   = '0;
          wd_nx    = '0;
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      SEND: begin
        if (clk_fe) begin
          idx_nx = bit_idx + BIT_IDX_W'(1);
          if (bit_idx < PAR_IDX)       data_oe_nx = ~tx_byte[bit_idx[2:0]];
          else if (bit_idx == PAR_IDX)  data_oe_nx = ~odd_parity(tx_byte);
          else if (bit_idx == STOP_IDX) state_nx = ACK;
          else                          state_nx = ERR;
        end
      end
      ACK: begin
        if (clk_fe) state_nx = data_s ? ERR : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) state_nx = IDLE;
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Device went quiet for too long.
    if (watched && !clk_fe && (wd_inc >= WD_W'(TIMEOUT_CYCLES))) state_nx = ERR;

    case (state_nx)
      IDLE, INHIBIT, ACK, ERR: data_oe_nx = 1'b0;
      START:                   data_oe_nx = 1'b1;
      default:                 ;
    endcase

    clk_oe_nx = (state_nx == INHIBIT) || (state_nx == START);
    busy_nx   = (state_nx != IDLE) && (state_nx != ERR);
    done_nx   = (state == WAIT_IDLE) && (state_nx == IDLE);
    err_nx    = (state_nx == ERR);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on an open-collector bus.
module tb_ps2_host_tx;

  localparam int INH  = 4800;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_busy, tx_done, tx_err, clk_oe, data_oe;
  logic       dev_clk, dev_data;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = dev_clk & ~clk_oe;
  assign ps2_data_line = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK      (clk),
    .RESET      (rst),
    .TX_DATA    (tx_data),
    .TX_REQ     (tx_req),
    .TX_BUSY    (tx_busy),
    .TX_DONE    (tx_done),
    .TX_ERR     (tx_err),
    .PS2_CLK_IN (ps2_clk_line),
    .PS2_DATA_IN(ps2_data_line),
    .PS2_CLK_OE (clk_oe),
    .PS2_DATA_OE(data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitors sampled on the falling clock edge.
  int   done_pulses = 0, err_pulses = 0, pulse_busy = 0, pulse_wide = 0, clk_oe_rises = 0;
  logic done_q = 1'b0, err_q = 1'b0, clk_oe_q = 1'b0;

  always @(negedge clk) begin
    if (tx_done && !done_q) done_pulses++;
    if (tx_err && !err_q) err_pulses++;
    if ((tx_done || tx_err) && tx_busy) pulse_busy++;
    if ((tx_done && done_q) || (tx_err && err_q)) pulse_wide++;
    if (clk_oe && !clk_oe_q) clk_oe_rises++;
    done_q   = tx_done;
    err_q    = tx_err;
    clk_oe_q = clk_oe;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [7:0] d);
    tx_data = d;
    tx_req  = 1'b1;
    cyc(1);
    tx_req  = 1'b0;
  endtask

  task automatic measure_hold(output int n_inh, output int n_hold);
    n_inh = 0;
    while (!data_oe && n_inh < 3 * INH) begin
      cyc(1);
      n_inh++;
    end
    n_hold = 0;
    while (clk_oe && n_hold < 1000) begin
      cyc(1);
      n_hold++;
    end
  endtask

  // Device: clocks out 10 bits after the start bit, then acks (or not); may abort after n_falls.
  task automatic dev_run(input int n_falls, input bit do_ack,
                         output logic [10:0] frame, output logic stop_oe);
    int w;
    frame   = '0;
    stop_oe = 1'b1;
    w = 0;
    while ((clk_oe || !data_oe) && w < 1000) begin
      cyc(1);
      w++;
    end
    cyc(HALF);
    frame[0] = ps2_data_line;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      cyc(HALF);
      if (k == n_falls) return;
      dev_clk = 1'b1;
      frame[4'(k)] = ps2_data_line;
      if (k == 10) stop_oe = data_oe;
      cyc(HALF);
    end
    if (do_ack) dev_data = 1'b0;
    cyc(5);
    dev_clk = 1'b0;
    cyc(HALF);
    dev_clk = 1'b1;
    cyc(HALF);
    dev_data = 1'b1;
    cyc(10);
  endtask

  task automatic full_txn(input logic [7:0] d, input logic [10:0] exp_frame, input string tag);
    int d0, e0, ni, nh;
    logic [10:0] fr;
    logic soe;
    d0 = done_pulses;
    e0 = err_pulses;
    start_req(d);
    chk({tag, "_busy_after_req"}, 32'(tx_busy), 32'd1);
    chk({tag, "_clk_oe_after_req"}, 32'(clk_oe), 32'd1);
    measure_hold(ni, nh);
    chk({tag, "_inhibit_cycles"}, 32'(ni), 32'(INH));
    chk({tag, "_start_hold"}, 32'(nh), 32'd16);
    dev_run(11, 1'b1, fr, soe);
    cyc(5);
    chk({tag, "_frame"}, 32'(fr), 32'(exp_frame));
    chk({tag, "_stop_data_oe"}, 32'(soe), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_pulses - d0), 32'd1);
    chk({tag, "_err_pulses"}, 32'(err_pulses - e0), 32'd0);
    chk({tag, "_busy_end"}, 32'(tx_busy), 32'd0);
  endtask

  initial begin
    int r0, e0, d0, w, k, ni, nh;
    logic [10:0] fr;
    logic soe;

    rst      = 1'b1;
    tx_req   = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("rst_clk_oe", 32'(clk_oe), 32'd0);
    chk("rst_data_oe", 32'(data_oe), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);

    full_txn(8'hED, 11'b11111011010, "ed");
    full_txn(8'h01, 11'b10000000010, "x01");
    full_txn(8'hFF, 11'b11111111110, "ff");
    chk("pulse_busy_overlap", 32'(pulse_busy), 32'd0);
    chk("pulse_width", 32'(pulse_wide), 32'd0);

    // Device never acks.
    d0 = done_pulses;
    e0 = err_pulses;
    start_req(8'h3C);
    measure_hold(ni, nh);
    dev_run(11, 1'b0, fr, soe);
    cyc(5);
    chk("noack_frame", 32'(fr), 32'(11'b11001111000));
    chk("noack_err_pulses", 32'(err_pulses - e0), 32'd1);
    chk("noack_done_pulses", 32'(done_pulses - d0), 32'd0);
    chk("noack_clk_oe", 32'(clk_oe), 32'd0);
    chk("noack_data_oe", 32'(data_oe), 32'd0);
    chk("noack_pulse_width", 32'(pulse_wide), 32'd0);

    // Device never clocks; a second request during the transfer is dropped.
    r0 = clk_oe_rises;
    e0 = err_pulses;
    d0 = done_pulses;
    start_req(8'hA5);
    cyc(100);
    tx_data = 8'h00;
    tx_req  = 1'b1;
    cyc(1);
    tx_req  = 1'b0;
    w = 0;
    while (clk_oe && w < 10000) begin
      cyc(1);
      w++;
    end
    k = 0;
    while (!tx_err && k < 3 * TO) begin
      cyc(1);
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'(TO));
    chk("timeout_busy", 32'(tx_busy), 32'd0);
    chk("timeout_data_oe", 32'(data_oe), 32'd0);
    chk("timeout_clk_oe", 32'(clk_oe), 32'd0);
    cyc(6000);
    chk("timeout_frames_started", 32'(clk_oe_rises - r0), 32'd1);
    chk("timeout_err_pulses", 32'(err_pulses - e0), 32'd1);
    chk("timeout_done_pulses", 32'(done_pulses - d0), 32'd0);

    // Reset in the middle of a frame, after the fifth device clock fall.
    start_req(8'hC3);
    measure_hold(ni, nh);
    dev_run(5, 1'b1, fr, soe);
    chk("midrst_busy_before", 32'(tx_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_clk_oe", 32'(clk_oe), 32'd0);
    chk("midrst_data_oe", 32'(data_oe), 32'd0);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    cyc(2);
    rst     = 1'b0;
    dev_clk = 1'b1;
    cyc(20);
    full_txn(8'h5A, 11'b11010110100, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
